// File: rtl/prog_loader.sv
// Boot loader: receives a LEN/data/CHK byte frame, writes the payload
// into the 32x8 program store from address 0, and releases the CPU from
// reset only once the frame checksum is valid.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset        synchronous active-high reset
//   byte_i       stream byte
//   byte_valid_i stream byte valid
//   byte_ready_o loader can accept a byte (IDLE/DATA/CHECK only)
//   load_req_i   one-cycle abort/restart request
//   mem_we_o     program memory write enable (one cycle per data byte)
//   mem_addr_o   program memory write address
//   mem_data_o   program memory write data
//   cpu_rst_o    CPU reset, low only while running
//   done_o       program loaded and checksum valid
//   err_o        framing or checksum error latched
module prog_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   input  logic              load_req_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      CHECK,
      RUN,
      ERR
   } state_t;

   localparam logic [8:0] MAX_LEN = 9'(DEPTH);
   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   rem;
   logic [ADDR_W:0]   rem_nx;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] wptr_nx;
   logic [7:0]        sum;
   logic [7:0]        sum_nx;
   logic [7:0]        chk_sum;
   logic              wr;
   logic              acc;
   logic              len_bad;

   assign byte_ready_o = !reset &&
                         (state == IDLE || state == DATA || state == CHECK);
   assign acc     = byte_valid_i && byte_ready_o;
   assign chk_sum = sum + byte_i;
   assign len_bad = (byte_i == 8'h00) || ({1'b0, byte_i} > MAX_LEN);

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state      <= IDLE;
         rem        <= '0;
         wptr       <= '0;
         sum        <= '0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         cpu_rst_o  <= 1'b1;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         state    <= state_nx;
         rem      <= rem_nx;
         wptr     <= wptr_nx;
         sum      <= sum_nx;
         mem_we_o <= wr;
         if (wr) begin
            mem_addr_o <= wptr;
            mem_data_o <= byte_i;
         end
         // Status outputs follow the state being entered, so they
         // change in the very first cycle of RUN or ERR.
         cpu_rst_o <= (state_nx != RUN);
         done_o    <= (state_nx == RUN);
         err_o     <= (state_nx == ERR);
      end
   end

   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      wptr_nx  = wptr;
      sum_nx   = sum;
      wr       = 1'b0;
      if (load_req_i) begin
         // Abort wins over a same-cycle byte: it is dropped unwritten.
         state_nx = IDLE;
         rem_nx   = '0;
         wptr_nx  = '0;
         sum_nx   = '0;
      end else if (acc) begin
         case (state)
            IDLE: begin
               if (len_bad) begin
                  state_nx = ERR;
               end else begin
                  rem_nx   = byte_i[ADDR_W:0];
                  sum_nx   = byte_i;
                  state_nx = DATA;
               end
            end
            DATA: begin
               wr      = 1'b1;
               sum_nx  = chk_sum;
               rem_nx  = rem - ONE;
               wptr_nx = wptr + 1'b1;
               if (rem == ONE) begin
                  state_nx = CHECK;
               end
            end
            CHECK: begin
               state_nx = (chk_sum == 8'h00) ? RUN : ERR;
            end
            default: begin
               state_nx = state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random
// frames, checked every cycle against a frame-level model.
module tb_prog_loader;

   logic       clk_i = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] byte_i = 8'h00;
   logic       byte_valid_i = 1'b0;
   logic       byte_ready_o;
   logic       load_req_i = 1'b0;
   logic       mem_we_o;
   logic [4:0] mem_addr_o;
   logic [7:0] mem_data_o;
   logic       cpu_rst_o;
   logic       done_o;
   logic       err_o;

   int errors = 0;
   int checks = 0;

   prog_loader #(.ADDR_W(5), .DEPTH(32)) dut (
      .clk_i        (clk_i),
      .reset        (reset),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .load_req_i   (load_req_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .cpu_rst_o    (cpu_rst_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Model: the bytes of the frame received so far determine everything.
   logic [7:0] fb[$];
   logic       m_we = 1'b0;
   logic [4:0] m_addr = '0;
   logic [7:0] m_data = '0;

   // 0 waiting for LEN, 1 loading, 2 running, 3 error
   function automatic int status();
      int len;
      int s;
      if (fb.size() == 0) return 0;
      len = int'(fb[0]);
      if (len == 0 || len > 32) return 3;
      if (fb.size() < len + 2) return 1;
      s = 0;
      foreach (fb[i]) s += int'(fb[i]);
      return (s % 256 == 0) ? 2 : 3;
   endfunction

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t wq[$];

   always @(posedge clk_i) begin
      int st;
      int n;
      int len;
      bit acc;
      st  = status();
      acc = byte_valid_i && !reset && (st == 0 || st == 1);
      m_we = 1'b0;
      if (reset) begin
         fb.delete();
         m_addr = '0;
         m_data = '0;
      end else if (load_req_i) begin
         fb.delete();
      end else if (acc) begin
         fb.push_back(byte_i);
         n   = fb.size();
         len = int'(fb[0]);
         if (len >= 1 && len <= 32 && n >= 2 && n <= len + 1) begin
            m_we   = 1'b1;
            m_addr = 5'(n - 2);
            m_data = byte_i;
         end
      end
      #1;
      st = status();
      chk("we", int'(mem_we_o), int'(m_we));
      chk("ready", int'(byte_ready_o), int'(!reset && (st == 0 || st == 1)));
      chk("cpu_rst", int'(cpu_rst_o), int'(st != 2));
      chk("done", int'(done_o), int'(st == 2));
      chk("err", int'(err_o), int'(st == 3));
      if (m_we) begin
         chk("addr", int'(mem_addr_o), int'(m_addr));
         chk("data", int'(mem_data_o), int'(m_data));
      end
      if (mem_we_o) wq.push_back({mem_addr_o, mem_data_o});
   end

   task automatic idle(input int n);
      repeat (n) begin
         byte_i = 8'($urandom);
         @(negedge clk_i);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      byte_i = b;
      byte_valid_i = 1'b1;
      while (!byte_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 50) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: byte %0h never accepted", b);
      end
      @(negedge clk_i);
      byte_valid_i = 1'b0;
   endtask

   task automatic pulse_req();
      load_req_i = 1'b1;
      @(negedge clk_i);
      load_req_i = 1'b0;
   endtask

   task automatic chk_wr(input string name, input int idx,
                         input int a, input int d);
      if (idx >= wq.size()) begin
         chk(name, -1, a);
      end else begin
         chk({name, "_addr"}, int'(wq[idx].addr), a);
         chk({name, "_data"}, int'(wq[idx].data), d);
      end
   endtask

   initial begin
      logic [7:0] q[$];
      int len;
      int s;
      int ab;
      int mode;
      int r;

      repeat (3) @(negedge clk_i);
      chk("rst_we", int'(mem_we_o), 0);
      chk("rst_addr", int'(mem_addr_o), 0);
      chk("rst_data", int'(mem_data_o), 0);
      chk("rst_cpu", int'(cpu_rst_o), 1);
      chk("rst_done", int'(done_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_ready", int'(byte_ready_o), 0);
      reset = 1'b0;
      @(negedge clk_i);
      chk("idle_ready", int'(byte_ready_o), 1);

      // Good frame, valid held high.
      wq.delete();
      send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
      idle(1);
      chk("good_done", int'(done_o), 1);
      chk("good_cpu", int'(cpu_rst_o), 0);
      chk("good_ready", int'(byte_ready_o), 0);
      chk("good_nwr", wq.size(), 2);
      chk_wr("good_w0", 0, 0, 'h11);
      chk_wr("good_w1", 1, 1, 'h22);
      byte_valid_i = 1'b1;
      idle(3);
      byte_valid_i = 1'b0;
      chk("run_nwr", wq.size(), 2);

      // Reload from RUN.
      pulse_req();
      chk("reload_cpu", int'(cpu_rst_o), 1);
      chk("reload_done", int'(done_o), 0);
      chk("reload_ready", int'(byte_ready_o), 1);

      // Bad checksum.
      wq.delete();
      send(8'h01); send(8'hAA); send(8'h00);
      chk("bad_err", int'(err_o), 1);
      chk("bad_cpu", int'(cpu_rst_o), 1);
      chk("bad_nwr", wq.size(), 1);
      chk_wr("bad_w0", 0, 0, 'hAA);
      idle(2);
      pulse_req();
      chk("bad_clr_err", int'(err_o), 0);
      chk("bad_clr_ready", int'(byte_ready_o), 1);

      // Illegal lengths.
      wq.delete();
      send(8'h00);
      chk("len0_err", int'(err_o), 1);
      pulse_req();
      send(8'h21);
      chk("len21_err", int'(err_o), 1);
      idle(1);
      chk("len_nwr", wq.size(), 0);
      pulse_req();

      // Full depth, valid toggling.
      wq.delete();
      send(8'h20);
      for (int i = 0; i < 32; i++) begin
         send(8'(i));
         idle(1);
      end
      send(8'hF0);
      chk("full_done", int'(done_o), 1);
      chk("full_nwr", wq.size(), 32);
      for (int i = 0; i < 32; i++) chk_wr("full_w", i, i, i);
      pulse_req();

      // Mid-frame abort coincident with a valid byte.
      wq.delete();
      send(8'h04); send(8'h01); send(8'h02);
      byte_i = 8'h03;
      byte_valid_i = 1'b1;
      load_req_i = 1'b1;
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      load_req_i = 1'b0;
      idle(1);
      chk("abort_nwr", wq.size(), 2);
      chk("abort_ready", int'(byte_ready_o), 1);
      chk("abort_cpu", int'(cpu_rst_o), 1);
      wq.delete();
      send(8'h01); send(8'h5A); send(8'hA5);
      chk("new_done", int'(done_o), 1);
      chk_wr("new_w0", 0, 0, 'h5A);
      pulse_req();

      // Random frames.
      for (int f = 0; f < 150; f++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0) len = 0;
         else if (r == 1) len = int'($urandom_range(33, 255));
         else len = int'($urandom_range(1, 32));
         q.delete();
         q.push_back(8'(len));
         if (len >= 1 && len <= 32) begin
            s = len;
            for (int i = 0; i < len; i++) begin
               q.push_back(8'($urandom));
               s += int'(q[i+1]);
            end
            s = 256 - (s % 256);
            if ($urandom_range(0, 4) == 0) s += 1;
            q.push_back(8'(s));
         end
         ab = ($urandom_range(0, 5) == 0) ?
              int'($urandom_range(0, q.size() - 1)) : -1;
         mode = int'($urandom_range(0, 1));
         for (int i = 0; i < q.size(); i++) begin
            if (i == ab) begin
               byte_i = q[i];
               byte_valid_i = 1'b1;
               if (mode == 1) reset = 1'b1;
               else load_req_i = 1'b1;
               @(negedge clk_i);
               byte_valid_i = 1'b0;
               reset = 1'b0;
               load_req_i = 1'b0;
               break;
            end
            send(q[i]);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
         end
         idle(2);
         if (!byte_ready_o) pulse_req();
         wq.delete();
      end

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the accumulator CPU and its 32x8 program store.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into program memory starting at address 0.
- Validates a checksum, then releases the CPU from reset.
- Holds the CPU in reset while loading and after any framing or checksum error; a reload can be requested at any time.

Parameters:
ADDR_W, 5, program memory address width (matches the 5-bit PC).
DEPTH, 32, maximum program length in bytes; must equal 2**ADDR_W.

Ports:
clk_i  input  1  system clock, all logic rising-edge.
reset  input  1  synchronous, active-high reset.
byte_i  input  8  incoming stream byte.
byte_valid_i  input  1  byte_i is valid this cycle.
byte_ready_o  output  1  loader accepts byte_i this cycle.
load_req_i  input  1  single-cycle request to abort or restart loading.
mem_we_o  output  1  program memory write enable.
mem_addr_o  output  ADDR_W  program memory write address.
mem_data_o  output  8  program memory write data.
cpu_rst_o  output  1  reset to the CPU; high = CPU held in reset.
done_o  output  1  program loaded and checksum valid; CPU running.
err_o  output  1  framing or checksum error latched.

Behaviour:
- Interface timing: one clock (clk_i); reset is synchronous and active-high.
- Handshake: a byte is accepted on a rising edge where byte_valid_i && byte_ready_o.
  - byte_ready_o is combinational from state: 1 in IDLE, DATA and CHECK; 0 in RUN and ERR; forced 0 while reset is high.
  - byte_i is ignored when no byte is accepted.
- Frame format: LEN byte, then LEN data bytes, then CHK byte.
  - Legal LEN is 1..DEPTH.
  - Valid frame: 8-bit sum (mod 256) of LEN, all data bytes and CHK equals 0x00.
- Reset values: state=IDLE, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_rst_o=1, done_o=0, err_o=0.
  - Internal byte counter and running sum are cleared to 0.
- IDLE:
  - On accepting LEN: LEN==0 or LEN>DEPTH goes to ERR.
  - Otherwise store LEN as remaining count, sum=LEN, go to DATA.
- DATA:
  - On each accepted byte, the next cycle drives mem_we_o=1 for exactly one cycle, with mem_data_o=byte and mem_addr_o=write pointer.
  - Write pointer starts at 0 and increments by 1 per byte; it never wraps because LEN≤DEPTH.
  - sum += byte (mod 256), remaining -= 1.
  - When remaining reaches 0, go to CHECK.
- CHECK: on accepting CHK, go to RUN if (sum+CHK) mod 256 == 0, else go to ERR.
- RUN:
  - cpu_rst_o=0 and done_o=1, registered: both change in the first cycle state==RUN.
  - Memory writes are never issued.
- ERR: err_o=1, cpu_rst_o=1, done_o=0. Remains in ERR until load_req_i or reset.
- load_req_i, in any state:
  - Next state IDLE; cpu_rst_o=1 from the next cycle.
  - done_o, err_o, write pointer and sum are cleared.
  - Priority over a same-cycle byte acceptance: that byte is dropped and any pending write is suppressed.
- Partially written memory is not cleared; only the new frame overwrites it.
- reset has priority over load_req_i.
- Reset mid-frame behaves exactly as load_req_i, and additionally returns all outputs to their reset values.
- cpu_rst_o is never low in any state other than RUN.

Test Plan:
- Good frame: LEN=0x02, data 0x11,0x22, CHK=0xCB, byte_valid_i held high -> writes (addr0,0x11) and (addr1,0x22), one cycle each; RUN; cpu_rst_o falls, done_o=1; byte_ready_o=0 thereafter.
- Bad checksum: LEN=0x01, data 0xAA, CHK=0x00 -> one write (addr0,0xAA); err_o=1; cpu_rst_o stays 1; then load_req_i pulse -> IDLE, err_o=0, byte_ready_o=1.
- Illegal length: LEN=0x00 and, separately, LEN=0x21 -> ERR immediately, no mem_we_o pulse.
- Full depth with gaps: LEN=0x20, data 0x00..0x1F with byte_valid_i toggling every other cycle, correct CHK -> 32 writes to addr 0..31 in order, no duplicate or missing writes, RUN reached.
- Mid-frame abort: LEN=0x04, two data bytes, then load_req_i coincident with a third valid byte -> third byte not written; IDLE; a new good frame LEN=0x01, data 0x5A, CHK=0xA5 loads and reaches RUN.
- Reload from RUN: in RUN, pulse load_req_i -> cpu_rst_o=1 next cycle, done_o=0, byte_ready_o=1.
